// File: rtl/datapath_sequencer.sv
// Hardwired fetch/decode/execute controller for the 16-register datapath.
// Emits the full control word each cycle; state, memory wait counter and fault are registered.
module datapath_sequencer #(
  parameter logic [4:0] FS_ADD      = 5'b00010,
  parameter logic [4:0] FS_SUB      = 5'b00101,
  parameter logic [4:0] FS_AND      = 5'b01100,
  parameter logic [4:0] FS_OR       = 5'b01101,
  parameter logic [4:0] FS_XOR      = 5'b01110,
  parameter logic [4:0] FS_PASSA    = 5'b00000,
  parameter logic [4:0] FS_PASSB    = 5'b01000,
  parameter int         MEM_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic [2:0]  NS,
  output logic [3:0]  SA,
  output logic [3:0]  SB,
  output logic [3:0]  DA,
  output logic        WR,
  output logic [4:0]  FS,
  output logic        C0,
  output logic        dp_reset,
  output logic        PCSEL,
  output logic [1:0]  PS,
  output logic        EN_ALU,
  output logic        ENADDRESS_ALU,
  output logic        IR_EN,
  output logic        ENADDRESS_PC,
  output logic        EN_PC,
  output logic        MW,
  output logic        MR,
  output logic        BSEL,
  output logic        ROM_EN,
  output logic [15:0] K,
  output logic        halted,
  output logic        fault
);

  // state  | meaning
  // RST    | one cycle of datapath reset after rst release
  // FETCH  | read ROM at PC, load IR, PC <- PC+1
  // DECODE | register selects from IR, no side effects
  // EXEC   | perform opcode; LD/ST issue address and go to MEM
  // MEM    | hold address/strobe until mem_ready or timeout
  // HALT   | idle forever, exit only via reset
  typedef enum logic [2:0] {
    ST_RST    = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_EXEC   = 3'b011,
    ST_MEM    = 3'b100,
    ST_HALT   = 3'b111
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic [3:0]    op;
  logic          unused_status;

  assign op            = ir[15:12];
  assign unused_status = ^status[3:1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fault_d       = fault_q;
    NS            = state_q;
    SA            = 4'h0;
    SB            = 4'h0;
    DA            = 4'h0;
    WR            = 1'b0;
    FS            = 5'b00000;
    C0            = 1'b0;
    dp_reset      = 1'b0;
    PCSEL         = 1'b0;
    PS            = 2'b00;
    EN_ALU        = 1'b0;
    ENADDRESS_ALU = 1'b0;
    IR_EN         = 1'b0;
    ENADDRESS_PC  = 1'b0;
    EN_PC         = 1'b0;
    MW            = 1'b0;
    MR            = 1'b0;
    BSEL          = 1'b0;
    ROM_EN        = 1'b0;
    K             = {{8{ir[7]}}, ir[7:0]};
    halted        = (state_q == ST_HALT);
    fault         = fault_q;

    if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM}) begin
      DA = ir[11:8];
      SA = ir[7:4];
      SB = ir[3:0];
    end

    case (state_q)
      ST_RST: begin
        dp_reset = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_FETCH: begin
        ROM_EN       = 1'b1;
        ENADDRESS_PC = 1'b1;
        IR_EN        = 1'b1;
        EN_PC        = 1'b1;
        PS           = 2'b01;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (op == 4'hF) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            WR     = 1'b1;
            EN_ALU = 1'b1;
            C0     = (op == 4'h2);
            case (op)
              4'h1:    FS = FS_ADD;
              4'h2:    FS = FS_SUB;
              4'h3:    FS = FS_AND;
              4'h4:    FS = FS_OR;
              default: FS = FS_XOR;
            endcase
          end
          4'h6: begin
            BSEL   = 1'b1;
            FS     = FS_PASSB;
            EN_ALU = 1'b1;
            WR     = 1'b1;
          end
          4'h7, 4'h8: begin
            FS            = FS_PASSA;
            ENADDRESS_ALU = 1'b1;
            MR            = (op == 4'h7);
            MW            = (op == 4'h8);
            cnt_d         = CNT_LOAD;
            state_d       = ST_MEM;
          end
          4'h9:    PS = status[0] ? 2'b10 : 2'b00;
          4'hA:    PS = status[0] ? 2'b00 : 2'b10;
          4'hB: begin
            PCSEL = 1'b1;
            PS    = 2'b11;
          end
          4'hC, 4'hD, 4'hE: fault_d = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        FS            = FS_PASSA;
        ENADDRESS_ALU = 1'b1;
        MR            = (op == 4'h7);
        MW            = (op == 4'h8);
        if (mem_ready) begin
          WR      = (op == 4'h7);
          state_d = ST_FETCH;
        end else if (cnt_q == '0) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HALT: ;
      default: state_d = ST_RST;
    endcase

    // Reset overrides everything combinationally so MR/MW/WR drop without a clock.
    if (!reset) begin
      NS            = 3'b000;
      SA            = 4'h0;
      SB            = 4'h0;
      DA            = 4'h0;
      WR            = 1'b0;
      FS            = 5'b00000;
      C0            = 1'b0;
      dp_reset      = 1'b1;
      PCSEL         = 1'b0;
      PS            = 2'b00;
      EN_ALU        = 1'b0;
      ENADDRESS_ALU = 1'b0;
      IR_EN         = 1'b0;
      ENADDRESS_PC  = 1'b0;
      EN_PC         = 1'b0;
      MW            = 1'b0;
      MR            = 1'b0;
      BSEL          = 1'b0;
      ROM_EN        = 1'b0;
      K             = 16'h0000;
      halted        = 1'b0;
      fault         = 1'b0;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench: instruction-level reference model pushes one expected control word per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_datapath_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic [3:0]  status;
  logic        mem_ready;
  logic [2:0]  NS;
  logic [3:0]  SA, SB, DA;
  logic        WR;
  logic [4:0]  FS;
  logic        C0, dp_reset, PCSEL;
  logic [1:0]  PS;
  logic        EN_ALU, ENADDRESS_ALU, IR_EN, ENADDRESS_PC, EN_PC, MW, MR, BSEL, ROM_EN;
  logic [15:0] K;
  logic        halted, fault;

  always #5 clock = ~clock;

  datapath_sequencer dut (
    .clock(clock), .reset(reset), .ir(ir), .status(status), .mem_ready(mem_ready),
    .NS(NS), .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0), .dp_reset(dp_reset),
    .PCSEL(PCSEL), .PS(PS), .EN_ALU(EN_ALU), .ENADDRESS_ALU(ENADDRESS_ALU), .IR_EN(IR_EN),
    .ENADDRESS_PC(ENADDRESS_PC), .EN_PC(EN_PC), .MW(MW), .MR(MR), .BSEL(BSEL),
    .ROM_EN(ROM_EN), .K(K), .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic [2:0]  ns;
    logic [3:0]  sa, sb, da;
    logic        wr;
    logic [4:0]  fs;
    logic        c0, dpr, pcsel;
    logic [1:0]  ps;
    logic        en_alu, ea_alu, ir_en, ea_pc, en_pc, mw, mr, bsel, rom_en;
    logic [15:0] k;
    logic        halted, fault;
  } cw_t;

  cw_t   exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    m_fault = 1'b0;
  int    cyc = 0;

  always @(posedge clock) cyc++;

  function automatic cw_t sample();
    cw_t a;
    a.ns = NS; a.sa = SA; a.sb = SB; a.da = DA; a.wr = WR; a.fs = FS; a.c0 = C0;
    a.dpr = dp_reset; a.pcsel = PCSEL; a.ps = PS; a.en_alu = EN_ALU; a.ea_alu = ENADDRESS_ALU;
    a.ir_en = IR_EN; a.ea_pc = ENADDRESS_PC; a.en_pc = EN_PC; a.mw = MW; a.mr = MR;
    a.bsel = BSEL; a.rom_en = ROM_EN; a.k = K; a.halted = halted; a.fault = fault;
    return a;
  endfunction

  // Monitor: the DUT presents a control word every cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        cw_t e, a;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = sample();
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", t, cyc, a, e);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  function automatic cw_t blank();
    cw_t c = '0;
    c.k     = 16'($signed(ir[7:0]));
    c.fault = m_fault;
    return c;
  endfunction

  function automatic cw_t with_sel(logic [15:0] iv, logic [2:0] ns);
    cw_t c = blank();
    c.ns = ns;
    c.da = iv[11:8];
    c.sa = iv[7:4];
    c.sb = iv[3:0];
    return c;
  endfunction

  function automatic logic [4:0] alu_code(logic [3:0] op);
    case (op)
      4'h1:    return 5'b00010;
      4'h2:    return 5'b00101;
      4'h3:    return 5'b01100;
      4'h4:    return 5'b01101;
      default: return 5'b01110;
    endcase
  endfunction

  task automatic expect_cycle(cw_t c, string t);
    exp_q.push_back(c);
    tag_q.push_back(t);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cw_t c;
    reset   = 1'b0;
    m_fault = 1'b0;
    repeat (2) begin
      c     = '0;
      c.dpr = 1'b1;
      expect_cycle(c, "reset_held");
    end
    reset = 1'b1;
    c     = blank();
    c.dpr = 1'b1;
    expect_cycle(c, "rst_state");
  endtask

  task automatic halt_cycles(int n);
    cw_t c;
    repeat (n) begin
      status    = 4'($urandom);
      mem_ready = 1'($urandom);
      c         = blank();
      c.ns      = 3'b111;
      c.halted  = 1'b1;
      expect_cycle(c, "halt");
    end
  endtask

  // One instruction at the instruction level; abort_at >= 0 pulls reset in that MEM cycle.
  task automatic do_instr(logic [15:0] iv, logic [3:0] st, int nwait, int abort_at = -1);
    cw_t        c;
    logic [3:0] op = iv[15:12];
    ir        = iv;
    status    = 4'($urandom);
    mem_ready = 1'($urandom);
    c = blank();
    c.ns = 3'b001; c.rom_en = 1'b1; c.ea_pc = 1'b1; c.ir_en = 1'b1; c.en_pc = 1'b1; c.ps = 2'b01;
    expect_cycle(c, "fetch");

    status    = 4'($urandom);
    mem_ready = 1'($urandom);
    expect_cycle(with_sel(iv, 3'b010), "decode");
    if (op == 4'hF) begin
      halt_cycles(5);
      return;
    end

    status    = st;
    mem_ready = 1'($urandom);
    c = with_sel(iv, 3'b011);
    if (op >= 4'h1 && op <= 4'h5) begin
      c.wr = 1'b1; c.en_alu = 1'b1; c.fs = alu_code(op); c.c0 = (op == 4'h2);
    end else if (op == 4'h6) begin
      c.bsel = 1'b1; c.fs = 5'b01000; c.en_alu = 1'b1; c.wr = 1'b1;
    end else if (op == 4'h7 || op == 4'h8) begin
      c.ea_alu = 1'b1; c.mr = (op == 4'h7); c.mw = (op == 4'h8);
    end else if (op == 4'h9) begin
      c.ps = st[0] ? 2'b10 : 2'b00;
    end else if (op == 4'hA) begin
      c.ps = st[0] ? 2'b00 : 2'b10;
    end else if (op == 4'hB) begin
      c.pcsel = 1'b1; c.ps = 2'b11;
    end
    expect_cycle(c, "exec");
    if (op >= 4'hC && op <= 4'hE) m_fault = 1'b1;
    if (op != 4'h7 && op != 4'h8) return;

    for (int i = 0; i < 8; i++) begin
      status    = 4'($urandom);
      mem_ready = (i == nwait);
      if (i == abort_at) begin
        mem_ready = 1'b0;
        #1;
        chk("mem_strobe_before_abort", {31'b0, (op == 4'h7) ? MR : MW}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_mr", {31'b0, MR}, 32'd0);
        chk("abort_mw", {31'b0, MW}, 32'd0);
        chk("abort_wr", {31'b0, WR}, 32'd0);
        chk("abort_ns", {29'b0, NS}, 32'd0);
        @(posedge clock);
        #1;
        do_reset();
        return;
      end
      c = with_sel(iv, 3'b100);
      c.ea_alu = 1'b1; c.mr = (op == 4'h7); c.mw = (op == 4'h8);
      if (i == nwait) c.wr = (op == 4'h7);
      expect_cycle(c, "mem");
      if (i == nwait) return;
    end
    m_fault = 1'b1;
    halt_cycles(4);
  endtask

  initial begin
    logic [3:0] rop;
    reset     = 1'b0;
    ir        = 16'h0000;
    status    = 4'h0;
    mem_ready = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    do_instr(16'h2312, 4'h0, 0);
    do_instr(16'h64F0, 4'h0, 0);
    do_instr(16'h7350, 4'h0, 2);
    do_instr(16'h8A10, 4'h0, 0);
    do_instr(16'h7350, 4'h0, 7);
    do_instr(16'h9006, 4'b0001, 0);
    do_instr(16'h9006, 4'b0000, 0);
    do_instr(16'hA0FA, 4'b0000, 0);
    do_instr(16'hA0FA, 4'b1111, 0);
    do_instr(16'hB500, 4'h0, 0);
    do_instr(16'h0000, 4'h0, 0);
    do_instr(16'hC123, 4'h0, 0);
    do_instr(16'h1456, 4'h0, 0);

    do_reset();
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 14));
      do_instr({rop, 12'($urandom)}, 4'($urandom), $urandom_range(0, 7));
    end

    do_reset();
    do_instr(16'h7350, 4'h0, 8);
    do_reset();
    do_instr(16'hF000, 4'h0, 0);
    do_reset();
    do_instr(16'h7350, 4'h0, 8, 1);
    do_instr(16'h8350, 4'h0, 8, 0);
    do_instr(16'h3ABC, 4'h0, 0);

    repeat (2) @(posedge clock);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
